// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a 64 B single-port data memory.
// Each accepted request gets one ACCESS cycle, then a done/err pulse and size-masked read data.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned MEM_AW = 6,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [63:0]       wdata0,
    input  logic [63:0]       wdata1,
    input  logic [1:0]        word0,
    input  logic [1:0]        word1,
    input  logic              we0,
    input  logic              we1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [63:0]       rdata0,
    output logic [63:0]       rdata1,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [63:0]       mem_dataw,
    output logic [1:0]        mem_word,
    output logic              mem_rw,
    input  logic [63:0]       mem_datar
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e              state_q, state_d;
    logic                last_q;
    logic                cmd_port_q, cmd_we_q, cmd_bad_q;
    logic [MEM_AW-1:0]   cmd_addr_q;
    logic [63:0]         cmd_wdata_q;
    logic [1:0]          cmd_word_q;
    logic                done0_q, done1_q, err0_q, err1_q;
    logic [63:0]         rdata0_q, rdata1_q;

    logic                hs;
    logic [ADDR_W-1:0]   sel_addr;
    logic [63:0]         sel_wdata;
    logic [1:0]          sel_word;
    logic                sel_we;
    logic                sel_bad;
    logic [MEM_AW:0]     span;
    logic [63:0]         rd_mask;
    logic                in_access;

    // Round-robin favours the port that was not served last; fixed mode always favours port 0.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (req0 && req1) begin
                if (RR_EN && !last_q) gnt1 = 1'b1;
                else                  gnt0 = 1'b1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign hs        = gnt0 | gnt1;
    assign sel_addr  = gnt1 ? addr1  : addr0;
    assign sel_wdata = gnt1 ? wdata1 : wdata0;
    assign sel_word  = gnt1 ? word1  : word0;
    assign sel_we    = gnt1 ? we1    : we0;

    // Reject addresses beyond the memory and accesses that would wrap past its top byte.
    assign span    = {1'b0, sel_addr[MEM_AW-1:0]} + ((MEM_AW + 1)'(1) << sel_word);
    assign sel_bad = (|sel_addr[ADDR_W-1:MEM_AW]) || (span > {1'b1, {MEM_AW{1'b0}}});

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (hs) state_d = StAccess;
            StAccess: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_mask = '1;
        unique case (cmd_word_q)
            2'b00:   rd_mask = 64'h0000_0000_0000_00ff;
            2'b01:   rd_mask = 64'h0000_0000_0000_ffff;
            2'b10:   rd_mask = 64'h0000_0000_ffff_ffff;
            default: rd_mask = '1;
        endcase
    end

    assign in_access = (state_q == StAccess);
    assign mem_addr  = in_access ? cmd_addr_q  : '0;
    assign mem_dataw = in_access ? cmd_wdata_q : '0;
    assign mem_word  = in_access ? cmd_word_q  : '0;
    assign mem_rw    = in_access & cmd_we_q & ~cmd_bad_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            cmd_port_q  <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_bad_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_word_q  <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q <= state_d;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            if (hs) begin
                cmd_port_q  <= gnt1;
                cmd_we_q    <= sel_we;
                cmd_bad_q   <= sel_bad;
                cmd_addr_q  <= sel_addr[MEM_AW-1:0];
                cmd_wdata_q <= sel_wdata;
                cmd_word_q  <= sel_word;
                last_q      <= gnt1;
            end
            if (in_access) begin
                if (!cmd_port_q) begin
                    done0_q <= 1'b1;
                    err0_q  <= cmd_bad_q;
                    if (cmd_bad_q)      rdata0_q <= '0;
                    else if (!cmd_we_q) rdata0_q <= mem_datar & rd_mask;
                end else begin
                    done1_q <= 1'b1;
                    err1_q  <= cmd_bad_q;
                    if (cmd_bad_q)      rdata1_q <= '0;
                    else if (!cmd_we_q) rdata1_q <= mem_datar & rd_mask;
                end
            end
        end
    end

    assign done0  = done0_q;
    assign done1  = done1_q;
    assign err0   = err0_q;
    assign err1   = err1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule
